// File: rtl/bcd_display_scan.sv
// Multiplexed common-anode seven-segment scanner for packed BCD results.
// Frame-synchronous commit, leading-zero blanking and inter-digit gap.
module bcd_display_scan #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 500,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic                  bcd_valid,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic                  conv_req,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] ONE = N_DIGITS'(1);

  typedef enum logic [1:0] {
    NODATA,
    ON,
    GAP
  } state_e;

  state_e                state_q;
  logic [DW-1:0]         div_q;
  logic [IW-1:0]         idx_q;
  logic [4*N_DIGITS-1:0] pend_q;
  logic [4*N_DIGITS-1:0] disp_q;
  logic [N_DIGITS-1:0]   pend_dp_q;
  logic [N_DIGITS-1:0]   disp_dp_q;
  logic                  pend_vld_q;
  logic                  disp_vld_q;

  logic       slot_end;
  logic       frame_end;
  logic       commit;
  logic       on_end;
  logic       blank;
  logic [3:0] digit;
  logic [6:0] seg_dec;
  logic [6:0] seg_d;

  assign slot_end  = div_q == DW'(REFRESH_DIV - 1);
  assign frame_end = slot_end && (idx_q == IW'(N_DIGITS - 1));
  assign commit    = frame_end && pend_vld_q;
  assign on_end    = div_q == DW'(REFRESH_DIV - GAP_CYCLES - 1);

  always_comb begin
    digit = disp_q[{idx_q, 2'b00} +: 4];
    blank = (BLANK_LZ != 0) && (idx_q != '0)
         && ((disp_q >> {idx_q, 2'b00}) == '0);
    unique case (digit)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b0111111;
    endcase
    seg_d = blank ? 7'b1111111 : seg_dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= NODATA;
      div_q      <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      disp_q     <= '0;
      pend_dp_q  <= '0;
      disp_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      disp_vld_q <= 1'b0;
      conv_req   <= 1'b0;
      an         <= '1;
      seg        <= '1;
      dp         <= 1'b1;
    end else begin
      conv_req <= (div_q == '0) && (idx_q == '0);

      if (bcd_valid) begin
        pend_q    <= bcd_in;
        pend_dp_q <= dp_mask;
      end
      pend_vld_q <= bcd_valid | (pend_vld_q & ~frame_end);

      if (commit) begin
        disp_q     <= pend_q;
        disp_dp_q  <= pend_dp_q;
        disp_vld_q <= 1'b1;
      end

      if (slot_end) begin
        div_q <= '0;
        idx_q <= frame_end ? '0 : idx_q + IW'(1);
      end else begin
        div_q <= div_q + DW'(1);
      end

      // Outputs reflect this cycle's state/idx/div one clock later.
      if (state_q == ON && disp_vld_q) begin
        an  <= ~(ONE << idx_q);
        seg <= seg_d;
        dp  <= ~disp_dp_q[idx_q];
      end else begin
        an  <= '1;
        seg <= '1;
        dp  <= 1'b1;
      end

      unique case (state_q)
        NODATA:  if (commit) state_q <= ON;
        ON:      if (on_end) state_q <= GAP;
        GAP:     if (slot_end) state_q <= ON;
        default: state_q <= NODATA;
      endcase
    end
  end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Multiplexed seven-segment driver that consumes the packed BCD result of the binary-to-BCD converter and scans it onto a common-anode display. It captures a result on the converter's one-cycle `done` pulse and holds it in a pending register. At each frame boundary it commits the pending value to the display register, so a frame never mixes old and new digits. It then time-multiplexes the digits with leading-zero blanking and an inter-digit ghosting gap, and issues a one-cycle conversion request per frame that drives the converter's `init`.

## Interface

Parameters:
- N_DIGITS, 4, number of BCD digits and anodes (2..8)
- REFRESH_DIV, 50000, clock cycles per digit slot (≥ GAP_CYCLES+2)
- GAP_CYCLES, 500, cycles at end of each slot with all anodes off (≥1)
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all digits

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- bcd_in  in  4*N_DIGITS  packed BCD; digit k = bcd_in[4k+3:4k], digit 0 = least significant
- bcd_valid  in  1  one-cycle pulse; bcd_in is valid in this cycle
- dp_mask  in  N_DIGITS  decimal point enable per digit, sampled with bcd_valid
- conv_req  out  1  one-cycle pulse at each frame start (to converter init)
- an  out  N_DIGITS  anode enables, active-low, one-hot-low or all high
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

## Operation

- Registers: pend (4*N_DIGITS) plus pend_dp; disp plus disp_dp; flags pend_vld and disp_vld; div counter; digit index idx.
- Capture: when bcd_valid=1, load pend and pend_dp and set pend_vld. A later bcd_valid before commit overwrites pend (last wins).
- Commit: at every frame boundary (idx wraps N_DIGITS-1→0 at slot end), if pend_vld is set: disp←pend, disp_dp←pend_dp, set disp_vld, clear pend_vld. If bcd_valid coincides with commit, commit the old pend and capture the new value into pend with pend_vld=1.
- FSM states:
  - NODATA: disp_vld=0; an all high, seg/dp all high. div and idx still run, so conv_req still fires. Go to ON at the first commit.
  - ON: drive an[idx]=0 and the decoded segments. Go to GAP when div = REFRESH_DIV-GAP_CYCLES-1.
  - GAP: an all high, seg/dp all high. Go to ON when div = REFRESH_DIV-1; div←0, idx←(idx+1) mod N_DIGITS.
- Decode: digits 0–9 use standard patterns (0=1000000, 1=1111001, 8=0000000, 9=0010000). Non-BCD values 10–15 show a dash: 0111111.
- Leading-zero blanking (BLANK_LZ=1): digit k is blanked (seg=1111111, an still low) when it and every higher digit are 0 and k≠0. Digit 0 is never blanked. The decimal point on a blanked digit is still shown if its disp_dp bit is set.
- conv_req=1 for exactly one cycle in the first cycle of each frame (idx=0, div=0), in every state.

## Timing

- Reset values: an all 1, seg 1111111, dp 1, conv_req 0, div 0, idx 0, pend_vld 0, disp_vld 0, state NODATA.
- Outputs are registered: seg, an and dp reflect the state/idx/div of the previous cycle (1-cycle latency).
- Slot length is REFRESH_DIV cycles: REFRESH_DIV-GAP_CYCLES cycles driven, then GAP_CYCLES dark.
- Frame length is N_DIGITS×REFRESH_DIV cycles.
- Capture-to-display latency is at most one frame plus one cycle.
- Reset mid-operation forces every register to its reset value immediately. The first conv_req after reset is released occurs on the first rising edge with rst low (div=0, idx=0).
- An X on bcd_in while bcd_valid=0 must not propagate.

## Test plan

- Reset, run 2 frames with no bcd_valid (N=4, DIV=8, GAP=2) -> an=1111 and seg=1111111 throughout; conv_req pulses every 32 cycles.
- bcd_valid with bcd_in=0x1234 -> after the next frame boundary, an cycles 1110,1101,1011,0111 with seg 2→0100100…; digit 0 shows 4=0011001; 2 dark cycles between slots.
- bcd_in=0x0007 with BLANK_LZ=1 -> digits 3..1 show seg=1111111 with their anode low; digit 0 shows 1111000. With BLANK_LZ=0, digits 3..1 show 1000000.
- bcd_in=0x00A5 -> digit 1 shows the dash 0111111, and digit 1 is not blanked.
- Two bcd_valid pulses (0x1111, then 0x2222) within one frame -> the next frame shows only 2222; bcd_valid coinciding with a frame boundary -> the old pend is shown this frame, the new value the next frame.
- rst asserted mid-slot while displaying -> outputs return to reset values asynchronously; after release the display stays dark until a new capture and commit.
